// File: rtl/ft4052c_pixel_capture_if.sv
// Valid/ready pixel stream from the capture block to the frame-store writer.
// Each word carries start-of-frame and end-of-line tags alongside the pixel.
interface ft4052c_pixel_capture_if;
  logic        M_VALID;
  logic        M_READY;
  logic [15:0] M_DATA;
  logic        M_SOF;
  logic        M_EOL;

  modport master (output M_VALID, output M_DATA, output M_SOF, output M_EOL, input M_READY);
  modport slave  (input M_VALID, input M_DATA, input M_SOF, input M_EOL, output M_READY);
endinterface

// File: rtl/ft4052c_pixel_capture.sv
// FT4052C pixel capture: row/column tracking, window crop, SOF/EOL tagging and an output FIFO.
// Optional test-pattern source enabled by defining FT_CAPTURE_TESTPAT_EN.
module ft4052c_pixel_capture #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned CNT_W      = 13
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        VA,
  input  logic        SSC,
  input  logic        ADC_W,
  input  logic [15:0] ADC_DATA,
  input  logic [15:0] OFFSET_X,
  input  logic [15:0] OFFSET_Y,
  input  logic [15:0] ACTIVE_X,
  input  logic [15:0] ACTIVE_Y,
`ifdef FT_CAPTURE_TESTPAT_EN
  input  logic        TESTPAT,
`endif
  ft4052c_pixel_capture_if.master m,
  output logic        FRAME_DONE,
  output logic        OVERFLOW,
  output logic [31:0] PIX_COUNT
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [AW:0]      PtrOne = (AW+1)'(1);

  typedef enum logic [1:0] {StArm, StIdle, StFrame, StDone} state_e;
  state_e state_q, state_d;

  logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
  logic             line_seen_q, line_seen_d;
  logic             ssc_q;
  logic [15:0]      off_x_q, off_y_q, act_x_q, act_y_q;
  logic             sof_armed_q, sof_armed_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      pix_count_q, pix_count_d;
  logic             stg_valid_q, stg_valid_d, stg_eol_q, stg_eol_d;
  logic [15:0]      stg_data_q, stg_data_d;

  logic [17:0]      mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [17:0]      rd_word;
  logic             fifo_empty, fifo_full, fifo_pop, fifo_wr, fifo_drop;

  logic             start, ssc_rise, sample, in_win, at_eol;
  logic [16:0]      col_w, row_w, end_x, end_y;
  logic [15:0]      pix_data;

  assign start    = (state_q == StIdle) & VA;
  assign ssc_rise = SSC & ~ssc_q;
  // VA low in the same cycle as a strobe discards it; strobes before the first line are ignored.
  assign sample   = (state_q == StFrame) & VA & ADC_W & ~SSC & line_seen_q;

  assign col_w  = 17'(col_q);
  assign row_w  = 17'(row_q);
  assign end_x  = 17'(off_x_q) + 17'(act_x_q);
  assign end_y  = 17'(off_y_q) + 17'(act_y_q);
  assign in_win = (col_w >= 17'(off_x_q)) && (col_w < end_x) &&
                  (row_w >= 17'(off_y_q)) && (row_w < end_y) &&
                  (col_q != CntMax) && (row_q != CntMax);
  assign at_eol = (col_w == end_x - 17'd1);

`ifdef FT_CAPTURE_TESTPAT_EN
  assign pix_data = TESTPAT ? {row_q[7:0], col_q[7:0]} : ADC_DATA;
`else
  assign pix_data = ADC_DATA;
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    line_seen_d = line_seen_q;
    stg_valid_d = 1'b0;
    stg_eol_d   = stg_eol_q;
    stg_data_d  = stg_data_q;
    unique case (state_q)
      StArm:  if (!VA) state_d = StIdle;
      StIdle: begin
        if (VA) begin
          state_d     = StFrame;
          row_d       = CntMax;
          col_d       = '0;
          line_seen_d = 1'b0;
        end
      end
      StFrame: begin
        if (!VA) begin
          state_d = StDone;
        end else if (ssc_rise) begin
          row_d       = !line_seen_q ? '0 : ((row_q == CntMax) ? row_q : row_q + CntOne);
          col_d       = '0;
          line_seen_d = 1'b1;
        end else if (sample) begin
          col_d       = (col_q == CntMax) ? col_q : col_q + CntOne;
          stg_valid_d = in_win;
          stg_eol_d   = at_eol;
          stg_data_d  = pix_data;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StArm;
    endcase
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_pop   = ~fifo_empty & m.M_READY;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign fifo_wr    = stg_valid_q & (~fifo_full | fifo_pop);
  assign fifo_drop  = stg_valid_q & fifo_full & ~fifo_pop;

  always_comb begin
    sof_armed_d = sof_armed_q;
    overflow_d  = overflow_q;
    pix_count_d = pix_count_q;
    if (start) begin
      sof_armed_d = 1'b1;
      overflow_d  = 1'b0;
      pix_count_d = '0;
    end else begin
      if (fifo_wr) begin
        sof_armed_d = 1'b0;
        pix_count_d = pix_count_q + 32'd1;
      end
      if (fifo_drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StArm;
      row_q       <= CntMax;
      col_q       <= '0;
      line_seen_q <= 1'b0;
      ssc_q       <= 1'b0;
      off_x_q     <= '0;
      off_y_q     <= '0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      sof_armed_q <= 1'b0;
      overflow_q  <= 1'b0;
      pix_count_q <= '0;
      stg_valid_q <= 1'b0;
      stg_eol_q   <= 1'b0;
      stg_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      line_seen_q <= line_seen_d;
      ssc_q       <= SSC;
      if (start) begin
        off_x_q <= OFFSET_X;
        off_y_q <= OFFSET_Y;
        act_x_q <= ACTIVE_X;
        act_y_q <= ACTIVE_Y;
      end
      sof_armed_q <= sof_armed_d;
      overflow_q  <= overflow_d;
      pix_count_q <= pix_count_d;
      stg_valid_q <= stg_valid_d;
      stg_eol_q   <= stg_eol_d;
      stg_data_q  <= stg_data_d;
      if (fifo_wr)  wr_ptr_q <= wr_ptr_q + PtrOne;
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge CLK) begin
    if (fifo_wr) mem_q[wr_ptr_q[AW-1:0]] <= {stg_eol_q, sof_armed_q, stg_data_q};
  end

  assign rd_word    = mem_q[rd_ptr_q[AW-1:0]];
  assign m.M_VALID  = ~fifo_empty;
  assign m.M_DATA   = fifo_empty ? '0 : rd_word[15:0];
  assign m.M_SOF    = ~fifo_empty & rd_word[16];
  assign m.M_EOL    = ~fifo_empty & rd_word[17];
  assign FRAME_DONE = (state_q == StDone);
  assign OVERFLOW   = overflow_q;
  assign PIX_COUNT  = pix_count_q;
endmodule

// File: tb/tb_ft4052c_pixel_capture.sv
// Directed bench for ft4052c_pixel_capture: window crop, backpressure, SSC strobes,
// empty window, mid-frame reset and (with FT_CAPTURE_TESTPAT_EN) the test pattern.
module tb_ft4052c_pixel_capture;
  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        VA, SSC, ADC_W, TESTPAT;
  logic [15:0] ADC_DATA, OFFSET_X, OFFSET_Y, ACTIVE_X, ACTIVE_Y;
  logic        FRAME_DONE, OVERFLOW;
  logic [31:0] PIX_COUNT;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [17:0] got_q [$];

  ft4052c_pixel_capture_if m_if ();

  ft4052c_pixel_capture #(.FIFO_DEPTH(4), .CNT_W(13)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .VA        (VA),
    .SSC       (SSC),
    .ADC_W     (ADC_W),
    .ADC_DATA  (ADC_DATA),
    .OFFSET_X  (OFFSET_X),
    .OFFSET_Y  (OFFSET_Y),
    .ACTIVE_X  (ACTIVE_X),
    .ACTIVE_Y  (ACTIVE_Y),
`ifdef FT_CAPTURE_TESTPAT_EN
    .TESTPAT   (TESTPAT),
`endif
    .m         (m_if),
    .FRAME_DONE(FRAME_DONE),
    .OVERFLOW  (OVERFLOW),
    .PIX_COUNT (PIX_COUNT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (m_if.M_VALID && m_if.M_READY) got_q.push_back({m_if.M_EOL, m_if.M_SOF, m_if.M_DATA});
    if (FRAME_DONE) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] pix(input int row, input int col);
    return 16'(32'hA000 + row * 256 + col);
  endfunction

  // SSC pulse, then n strobes every other cycle carrying pix(row, col).
  task automatic do_line(input int row, input int n);
    SSC = 1'b1; tick(1);
    SSC = 1'b0; tick(1);
    for (int c = 0; c < n; c++) begin
      ADC_W = 1'b1; ADC_DATA = pix(row, c); tick(1);
      ADC_W = 1'b0; tick(1);
    end
  endtask

  task automatic set_win(input int ox, input int ax, input int oy, input int ay);
    OFFSET_X = 16'(ox); ACTIVE_X = 16'(ax); OFFSET_Y = 16'(oy); ACTIVE_Y = 16'(ay);
  endtask

  initial begin
    int d0;
    logic [17:0] exp_w;
    RESET_N = 1'b0; VA = 1'b0; SSC = 1'b0; ADC_W = 1'b0; TESTPAT = 1'b0;
    ADC_DATA = '0; m_if.M_READY = 1'b1;
    set_win(0, 0, 0, 0);
    tick(2);
    check("rst_valid", 32'(m_if.M_VALID), 0);
    check("rst_data", 32'(m_if.M_DATA), 0);
    check("rst_sof_eol", {30'd0, m_if.M_SOF, m_if.M_EOL}, 0);
    check("rst_done", 32'(FRAME_DONE), 0);
    check("rst_ovf", 32'(OVERFLOW), 0);
    check("rst_cnt", PIX_COUNT, 0);
    RESET_N = 1'b1;
    tick(3);

    // Window crop
    set_win(2, 3, 1, 2);
    got_q.delete();
    VA = 1'b1; tick(2);
    for (int r = 0; r < 3; r++) do_line(r, 8);
    tick(6);
    check("crop_n", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      exp_w = {(i % 3 == 2) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, pix(1 + i / 3, 2 + i % 3)};
      check($sformatf("crop_w%0d", i), 32'(got_q[i]), 32'(exp_w));
    end
    check("crop_cnt", PIX_COUNT, 6);
    d0 = done_cnt;
    VA = 1'b0; tick(1);
    check("crop_done_hi", 32'(FRAME_DONE), 1);
    tick(1);
    check("crop_done_lo", 32'(FRAME_DONE), 0);
    check("crop_done_n", done_cnt - d0, 1);

    // Backpressure / overflow with a 4-entry FIFO
    set_win(0, 6, 0, 1);
    m_if.M_READY = 1'b0;
    got_q.delete();
    VA = 1'b1; tick(2);
    do_line(0, 6);
    tick(3);
    check("bp_ovf", 32'(OVERFLOW), 1);
    check("bp_cnt", PIX_COUNT, 4);
    check("bp_head", {14'd0, m_if.M_EOL, m_if.M_SOF, m_if.M_DATA}, {16'd0, 2'b01, pix(0, 0)});
    tick(5);
    check("bp_stable", 32'(m_if.M_DATA), 32'(pix(0, 0)));
    check("bp_valid", 32'(m_if.M_VALID), 1);
    VA = 1'b0; tick(3);
    m_if.M_READY = 1'b1; tick(8);
    check("bp_n", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("bp_w%0d", i), 32'(got_q[i]), {14'd0, 1'b0, (i == 0) ? 1'b1 : 1'b0, pix(0, i)});

    // Strobes before the first line and during SSC are ignored
    set_win(0, 1, 0, 1);
    got_q.delete();
    VA = 1'b1; tick(2);
    check("ssc_ovf_clr", 32'(OVERFLOW), 0);
    ADC_W = 1'b1; ADC_DATA = 16'hBAD1; tick(1);
    ADC_W = 1'b0; tick(1);
    SSC = 1'b1; ADC_W = 1'b1; ADC_DATA = 16'hBAD2; tick(1);
    ADC_DATA = 16'hBAD3; tick(1);
    SSC = 1'b0; ADC_W = 1'b0; tick(1);
    ADC_W = 1'b1; ADC_DATA = 16'h1234; tick(1);
    ADC_W = 1'b0; tick(6);
    check("ssc_n", got_q.size(), 1);
    if (got_q.size() > 0) check("ssc_w0", 32'(got_q[0]), {14'd0, 2'b11, 16'h1234});
    VA = 1'b0; tick(3);

    // Empty window
    set_win(0, 4, 0, 0);
    got_q.delete();
    d0 = done_cnt;
    VA = 1'b1; tick(2);
    do_line(0, 4);
    tick(3);
    VA = 1'b0; tick(1);
    check("empty_done_hi", 32'(FRAME_DONE), 1);
    tick(4);
    check("empty_done_n", done_cnt - d0, 1);
    check("empty_n", got_q.size(), 0);
    check("empty_cnt", PIX_COUNT, 0);

    // Reset mid-frame
    set_win(0, 8, 0, 1);
    m_if.M_READY = 1'b0;
    VA = 1'b1; tick(2);
    do_line(0, 3);
    tick(3);
    check("mrst_pre_valid", 32'(m_if.M_VALID), 1);
    RESET_N = 1'b0; #1;
    check("mrst_valid", 32'(m_if.M_VALID), 0);
    tick(1);
    RESET_N = 1'b1; tick(1);
    do_line(0, 3);
    tick(3);
    check("mrst_no_cap", 32'(m_if.M_VALID), 0);
    check("mrst_cnt", PIX_COUNT, 0);
    VA = 1'b0; tick(3);
    m_if.M_READY = 1'b1;
    got_q.delete();
    VA = 1'b1; tick(2);
    do_line(0, 2);
    tick(6);
    check("mrst_n", got_q.size(), 2);
    if (got_q.size() > 1) begin
      check("mrst_w0", 32'(got_q[0]), {14'd0, 2'b01, pix(0, 0)});
      check("mrst_w1", 32'(got_q[1]), {14'd0, 2'b00, pix(0, 1)});
    end
    VA = 1'b0; tick(3);

`ifdef FT_CAPTURE_TESTPAT_EN
    set_win(5, 1, 1, 1);
    TESTPAT = 1'b1;
    got_q.delete();
    VA = 1'b1; tick(2);
    do_line(0, 8);
    do_line(1, 8);
    tick(6);
    check("tp_n", got_q.size(), 1);
    if (got_q.size() > 0) check("tp_w0", 32'(got_q[0]), {14'd0, 2'b11, 16'h0105});
    VA = 1'b0; TESTPAT = 1'b0; tick(3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ft4052c_pixel_capture.md
# ft4052c_pixel_capture

Downstream consumer of the FT4052C sensor timing generator. Samples the 16-bit ADC word on every ADC write strobe during readout and tracks row/column position from the VA and SSC timing outputs. Crops the active window, tags start-of-frame and end-of-line, and buffers pixels in a FIFO. Presents them as a valid/ready stream to the frame-store writer.

## Interface
- FIFO_DEPTH, 64 — output FIFO entries; power of two, at least 4
- CNT_W, 13 — row/column counter width; covers 4763 columns × 5356 rows
- CLK  in  1  — system clock; the same clock as the timing generator
- RESET_N  in  1  — asynchronous, active-low reset
- VA  in  1  — readout active; high for the whole frame
- SSC  in  1  — horizontal transfer; a rising edge marks a new line
- ADC_W  in  1  — one-cycle sample strobe (HDR_ADC_W)
- ADC_DATA  in  16  — ADC word; valid in the cycle ADC_W is high
- OFFSET_X, OFFSET_Y  in  16 each  — window origin in samples/rows
- ACTIVE_X, ACTIVE_Y  in  16 each  — window size; 0 means an empty window
- TESTPAT  in  1  — test-pattern select; only present when the macro below is defined
- M_VALID  out  1  — output word valid
- M_READY  in  1  — downstream accepts the word
- M_DATA  out  16  — pixel word
- M_SOF  out  1  — first pixel of the window
- M_EOL  out  1  — last pixel of a window row
- FRAME_DONE  out  1  — one-cycle pulse after VA falls
- OVERFLOW  out  1  — sticky; a pixel was dropped because the FIFO was full
- PIX_COUNT  out  32  — pixels written into the FIFO in the current or last frame

## Operation
- **States**
  - ARM: waits for VA low. Entered from reset.
  - IDLE: waits for a VA rising edge.
  - FRAME: active readout.
  - DONE: single cycle, then IDLE.
- **IDLE → FRAME on VA rise**
  - row = all-ones, so the first SSC rise gives row 0.
  - col = 0; OVERFLOW cleared; PIX_COUNT cleared; SOF flag armed.
- **In FRAME**
  - SSC rise: row += 1, col = 0.
  - ADC_W & ~SSC: sample accepted, then col += 1.
  - ADC_W while SSC is high: ignored.
  - Samples before the first SSC rise: ignored.
- **Window test**
  - OFFSET_X ≤ col < OFFSET_X + ACTIVE_X, and OFFSET_Y ≤ row < OFFSET_Y + ACTIVE_Y.
  - Compare in 17-bit arithmetic, so the sums never wrap.
- **In-window sample:** push {EOL, SOF, data}.
  - EOL = (col == OFFSET_X + ACTIVE_X − 1).
  - SOF = armed flag; the flag is cleared on the first push.
- **Counters saturate**
  - col and row saturate at all-ones and never wrap.
  - A sample at a saturated position is outside any window that fits in CNT_W.
- **FIFO full**
  - The sample is dropped and OVERFLOW is set.
  - PIX_COUNT does not increment.
  - The SOF flag stays armed if the dropped sample carried SOF.
- **FRAME → DONE on VA fall:** FRAME_DONE = 1 for one cycle. The FIFO is not flushed.
- **Empty window:** ACTIVE_X = 0 or ACTIVE_Y = 0 means no pushes; FRAME_DONE still pulses.
- **Simultaneous events**
  - SSC rise and ADC_W in the same cycle: the strobe is ignored, because SSC is high.
  - VA fall and ADC_W in the same cycle: the sample is discarded.
- OFFSET and ACTIVE inputs are latched on the VA rise; changes mid-frame have no effect.

## Timing
- **Reset (async assert, sync release):**
  - M_VALID = 0; M_DATA = 0; M_SOF = 0; M_EOL = 0.
  - FRAME_DONE = 0; OVERFLOW = 0; PIX_COUNT = 0.
  - FIFO empty; state = ARM.
- **Reset mid-frame:** FIFO contents are lost. No capture resumes until VA has gone low and risen again.
- **Latency**
  - ADC_W at cycle n: FIFO write at n+1.
  - M_VALID at n+2 at the earliest, when the FIFO was empty.
- **Handshake**
  - Transfer occurs when M_VALID & M_READY.
  - M_DATA, M_SOF and M_EOL stay stable while M_VALID & ~M_READY.
  - M_VALID never drops without a transfer.
- **Full FIFO with a pop in the same cycle:** a write in that cycle succeeds; no overflow.
- **Throughput:** one write and one read per cycle. A strobe every 3 cycles is sustained with M_READY held high.
- **FRAME_DONE:** asserted in the cycle after the cycle VA is sampled low.

## Configuration
- FT_CAPTURE_TESTPAT_EN
  - **Defined:** TESTPAT port exists. With TESTPAT = 1, the pushed data is {row[7:0], col[7:0]} in place of ADC_DATA. Windowing, flags and timing are unchanged.
  - **Undefined:** the port and the mux are absent, and ADC_DATA always passes through.

## Test plan
- **Window crop:** OFFSET_X = 2, ACTIVE_X = 3, OFFSET_Y = 1, ACTIVE_Y = 2; 3 lines of 8 strobes; M_READY = 1.
  - Expect 6 words: row 1 cols 2–4, then row 2 cols 2–4.
  - M_SOF on the first word only; M_EOL on words 3 and 6; PIX_COUNT = 6.
- **Backpressure / overflow:** FIFO_DEPTH = 4, M_READY = 0, 6 in-window strobes.
  - Exactly 4 words are held and OVERFLOW = 1.
  - Raising M_READY drains those 4 in order, with stable data while stalled.
- **Strobe during SSC:** ADC_W asserted in the SSC-rise cycle and while SSC is high.
  - Not captured; col stays 0.
- **Frame end:** VA falls with the window empty (ACTIVE_Y = 0).
  - No words; FRAME_DONE pulses once, 1 cycle after VA low is sampled.
- **Reset mid-frame:** RESET_N low with 3 words queued, released while VA is high.
  - M_VALID = 0 immediately.
  - No capture until VA falls and rises again.
  - The next frame's first word carries M_SOF.
- **Test pattern (macro defined):** TESTPAT = 1, row 1, col 5.
  - M_DATA = 0x0105.
